// File: rtl/clk_div_switch_if.sv
// clk_div_switch_if: ratio-change handshake between control logic and the divider.
//   div_req  : request strobe (master -> divider)
//   div_val  : requested ratio, captured on accept (master -> divider)
//   div_busy : switch in progress, requests ignored (divider -> master)
//   div_done : one-cycle pulse when the new ratio starts (divider -> master)
//   div_cur  : ratio currently driving clk_o (divider -> master)
interface clk_div_switch_if #(
  parameter int unsigned CNT_W = 8
);
  logic             div_req;
  logic [CNT_W-1:0] div_val;
  logic             div_busy;
  logic             div_done;
  logic [CNT_W-1:0] div_cur;

  modport master (
    output div_req,
    output div_val,
    input  div_busy,
    input  div_done,
    input  div_cur
  );

  modport slave (
    input  div_req,
    input  div_val,
    output div_busy,
    output div_done,
    output div_cur
  );
endinterface

// File: rtl/clk_div_switch.sv
// clk_div_switch: glitch-free programmable clock divider with run-time ratio change.
// The old ratio finishes its period, clk_o is held low for GUARD extra cycles, then
// the new ratio starts with a high phase on the same edge that pulses div_done.
//   clk    : source clock; all state lives in this domain
//   rst_n  : asynchronous active-low reset; aborts any switch in progress
//   bus    : slave side of clk_div_switch_if (div_req/div_val/div_busy/div_done/div_cur)
//   clk_o  : divided clock (flop output; gated clk while in bypass)
// Optional feature macro: CLK_DIV_SWITCH_BYPASS_EN -- div_val=1 selects clk_o = clk
// gated by a negedge enable flop. Undefined: div_val of 0 or 1 clamps to 2.
module clk_div_switch #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 2,
  parameter int unsigned GUARD   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_div_switch_if.slave  bus,
  output logic             clk_o
);

  localparam int unsigned     G_W    = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [G_W-1:0]  G_LAST = (GUARD == 0) ? '0 : G_W'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_GUARD,
    ST_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic [G_W-1:0]   gcnt_q, gcnt_d;
  logic             clk_q, clk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] half;
  logic             cnt_last;
  logic             accept;
  logic             drain_exit;

`ifdef CLK_DIV_SWITCH_BYPASS_EN
  logic             byp_en;
  logic             byp_mode;
  assign byp_mode = (cur_q == CNT_W'(1));
`endif

  // Effective ratio for the requested value
  always_comb begin
`ifdef CLK_DIV_SWITCH_BYPASS_EN
    eff = (bus.div_val == '0) ? CNT_W'(2) : bus.div_val;
`else
    eff = (bus.div_val < CNT_W'(2)) ? CNT_W'(2) : bus.div_val;
`endif
  end

  assign half     = cur_q >> 1;
  assign cnt_last = (cnt_q == cur_q - CNT_W'(1));
  assign accept   = bus.div_req && !busy_q && (state_q == ST_RUN);

  // Next-state and next-output logic; clk_d reflects the phase of the current cnt,
  // so a reset cnt of 0 yields a rising clk_o on the first edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    cap_d      = cap_q;
    gcnt_d     = gcnt_q;
    clk_d      = clk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drain_exit = cnt_last;

    clk_d = (cnt_q < half);
    cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
`ifdef CLK_DIV_SWITCH_BYPASS_EN
    // In bypass the flop stays low; the old ratio ends once byp_en has dropped
    if (byp_mode) begin
      clk_d      = 1'b0;
      cnt_d      = '0;
      drain_exit = !byp_en;
    end
`endif

    // busy covers the done cycle, then releases
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          cap_d  = eff;
          busy_d = 1'b1;
          gcnt_d = '0;
          if (drain_exit) state_d = (GUARD == 0) ? ST_LOAD : ST_GUARD;
          else            state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_exit) begin
          gcnt_d  = '0;
          state_d = (GUARD == 0) ? ST_LOAD : ST_GUARD;
        end
      end
      ST_GUARD: begin
        clk_d  = 1'b0;
        cnt_d  = '0;
        gcnt_d = gcnt_q + G_W'(1);
        if (gcnt_q == G_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // New ratio starts: high phase position 0 is emitted on this edge
        cur_d   = cap_q;
        done_d  = 1'b1;
        state_d = ST_RUN;
        clk_d   = 1'b1;
        cnt_d   = CNT_W'(1);
`ifdef CLK_DIV_SWITCH_BYPASS_EN
        if (cap_q == CNT_W'(1)) begin
          clk_d = 1'b0;
          cnt_d = '0;
        end
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      cur_q   <= CNT_W'(DEF_DIV);
      cap_q   <= CNT_W'(DEF_DIV);
      gcnt_q  <= '0;
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      cap_q   <= cap_d;
      gcnt_q  <= gcnt_d;
      clk_q   <= clk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CLK_DIV_SWITCH_BYPASS_EN
  // Bypass gate enable changes only while clk is low, so no partial pulses
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_en <= 1'b0;
    end else if (state_q == ST_LOAD && cap_q == CNT_W'(1)) begin
      byp_en <= 1'b1;
    end else if (state_q == ST_DRAIN) begin
      byp_en <= 1'b0;
    end
  end

  assign clk_o = clk_q | (clk & byp_en);
`else
  assign clk_o = clk_q;
`endif

  assign bus.div_busy = busy_q;
  assign bus.div_done = done_q;
  assign bus.div_cur  = cur_q;

endmodule

// File: tb/tb_clk_div_switch.sv
// tb_clk_div_switch: directed bench for clk_div_switch (CNT_W=8, DEF_DIV=2, GUARD=2).
module tb_clk_div_switch;

  logic clk;
  logic rst_n;
  logic clk_o;
  int   total;
  int   bad;

  clk_div_switch_if #(.CNT_W(8)) bus ();

  clk_div_switch #(
    .CNT_W   (8),
    .DEF_DIV (2),
    .GUARD   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .clk_o (clk_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.div_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk1({tag, "_done"}, bus.div_done, 1'b1);
  endtask

  task automatic request(input logic [7:0] val);
    bus.div_val = val;
    bus.div_req = 1'b1;
    step();
    bus.div_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b1;
    bus.div_req = 1'b0;
    bus.div_val = 8'd0;
    #1 rst_n = 1'b0;
    #11;

    // Reset values
    chk1("rst_clk_o", clk_o, 1'b0);
    chk8("rst_cur", bus.div_cur, 8'd2);
    chk1("rst_busy", bus.div_busy, 1'b0);
    chk1("rst_done", bus.div_done, 1'b0);

    // Release: first edge raises clk_o, then divide by 2
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk1("div2_e1", clk_o, 1'b1);
    step(); chk1("div2_e2", clk_o, 1'b0);
    step(); chk1("div2_e3", clk_o, 1'b1);
    step(); chk1("div2_e4", clk_o, 1'b0);
    chk8("div2_cur", bus.div_cur, 8'd2);
    chk1("div2_busy", bus.div_busy, 1'b0);

    // Switch to 4, then align to cnt=1
    request(8'd4);
    chk1("to4_busy", bus.div_busy, 1'b1);
    wait_done("to4");
    chk8("to4_cur", bus.div_cur, 8'd4);
    chk1("to4_hi0", clk_o, 1'b1);
    step(); chk1("to4_hi1", clk_o, 1'b1); chk1("to4_busy_clr", bus.div_busy, 1'b0);
    step(); chk1("to4_lo0", clk_o, 1'b0);
    step(); chk1("to4_lo1", clk_o, 1'b0);
    step(); chk1("to4_hi2", clk_o, 1'b1);

    // 4 -> 7 requested at cnt=1; a second request (9) is held during busy and done
    bus.div_val = 8'd7;
    bus.div_req = 1'b1;
    step();
    chk1("to7_acc_busy", bus.div_busy, 1'b1);
    chk1("to7_acc_clk", clk_o, 1'b1);
    bus.div_val = 8'd9;
    step(); chk1("to7_drain0", clk_o, 1'b0);
    step(); chk1("to7_drain1", clk_o, 1'b0); chk1("to7_nodone1", bus.div_done, 1'b0);
    step(); chk1("to7_guard0", clk_o, 1'b0);
    step(); chk1("to7_guard1", clk_o, 1'b0); chk1("to7_nodone2", bus.div_done, 1'b0);
    chk1("to7_busy_g", bus.div_busy, 1'b1);
    step();
    chk1("to7_done", bus.div_done, 1'b1);
    chk8("to7_cur", bus.div_cur, 8'd7);
    chk1("to7_hi0", clk_o, 1'b1);
    chk1("to7_busy_done", bus.div_busy, 1'b1);
    step();
    chk1("to7_done_clr", bus.div_done, 1'b0);
    chk1("to7_busy_clr", bus.div_busy, 1'b0);
    chk1("to7_hi1", clk_o, 1'b1);
    bus.div_req = 1'b0;
    step();
    chk1("to7_hi2", clk_o, 1'b1);
    chk1("ign_busy", bus.div_busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); chk1("to7_lo", clk_o, 1'b0);
    end
    step(); chk1("to7_hi_next", clk_o, 1'b1);
    chk8("ign_cur", bus.div_cur, 8'd7);

    // div_val=0 clamps to 2
    request(8'd0);
    wait_done("clamp0");
    chk8("clamp0_cur", bus.div_cur, 8'd2);
    chk1("clamp0_p0", clk_o, 1'b1);
    step(); chk1("clamp0_p1", clk_o, 1'b0);
    step(); chk1("clamp0_p2", clk_o, 1'b1);
    step(); chk1("clamp0_p3", clk_o, 1'b0);

`ifndef CLK_DIV_SWITCH_BYPASS_EN
    // div_val=1 clamps to 2 without bypass
    request(8'd1);
    wait_done("clamp1");
    chk8("clamp1_cur", bus.div_cur, 8'd2);
    chk1("clamp1_p0", clk_o, 1'b1);
    step(); chk1("clamp1_p1", clk_o, 1'b0);
    step(); chk1("clamp1_p2", clk_o, 1'b1);
    step(); chk1("clamp1_p3", clk_o, 1'b0);
`endif

    // Reset during GUARD (N=2, accept at cnt=0: one drain edge, then guard)
    request(8'd5);
    chk1("rg_acc_busy", bus.div_busy, 1'b1);
    chk1("rg_acc_clk", clk_o, 1'b1);
    step(); chk1("rg_drain_clk", clk_o, 1'b0);
    step(); chk1("rg_guard_clk", clk_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("rg_clk_o", clk_o, 1'b0);
    chk1("rg_busy", bus.div_busy, 1'b0);
    chk8("rg_cur", bus.div_cur, 8'd2);
    chk1("rg_done", bus.div_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk1("rg_rel_clk", clk_o, 1'b1);
    chk1("rg_rel_done", bus.div_done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("rg_run_clk", clk_o, (i % 2 == 0) ? 1'b0 : 1'b1);
      chk1("rg_run_nodone", bus.div_done, 1'b0);
    end
    chk8("rg_run_cur", bus.div_cur, 8'd2);

`ifdef CLK_DIV_SWITCH_BYPASS_EN
    // Bypass entry: clk_o follows clk from the done edge
    request(8'd1);
    chk1("byp_acc_busy", bus.div_busy, 1'b1);
    wait_done("byp_in");
    chk8("byp_cur", bus.div_cur, 8'd1);
    chk1("byp_hi", clk_o, 1'b1);
    #5 chk1("byp_lo", clk_o, 1'b0);
    #5 chk1("byp_hi2", clk_o, 1'b1);
    chk1("byp_busy_clr", bus.div_busy, 1'b0);
    // Bypass exit to 3: full pulse at accept, then low until the new ratio
    request(8'd3);
    chk1("byx_acc_clk", clk_o, 1'b1);
    chk1("byx_acc_busy", bus.div_busy, 1'b1);
    #5 chk1("byx_neg", clk_o, 1'b0);
    #5 chk1("byx_drain", clk_o, 1'b0);
    wait_done("byp_out");
    chk8("byx_cur", bus.div_cur, 8'd3);
    chk1("byx_p0", clk_o, 1'b1);
    step(); chk1("byx_p1", clk_o, 1'b0);
    step(); chk1("byx_p2", clk_o, 1'b0);
    step(); chk1("byx_p3", clk_o, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
